// File: rtl/inst_rom_pkg.sv
// Shared constants, loader FSM state encoding and byte-placement helper
// for the instruction ROM and its boot loader.
package inst_rom_pkg;

    localparam int INST_MEM_NUM_LOG2 = 10;
    localparam int INST_MEM_NUM      = 1 << INST_MEM_NUM_LOG2;
    localparam int INST_BUS_W        = 32;
    localparam int INST_ADDR_BUS_W   = 32;

    localparam logic        RST_ENABLE_N = 1'b0;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        LD_LOAD  = 2'd0,
        LD_FLUSH = 2'd1,
        LD_DONE  = 2'd2
    } ld_state_t;

    // Big-endian placement: byte 0 lands in [31:24], byte 3 in [7:0].
    function automatic logic [31:0] place_byte(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  data);
        logic [31:0] result;
        result = word;
        case (idx)
            2'd0:    result[31:24] = data;
            2'd1:    result[23:16] = data;
            2'd2:    result[15:8]  = data;
            default: result[7:0]   = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/inst_rom_if.sv
// Fetch port plus boot-loader byte stream of the instruction ROM.
// The master side is the core/boot source, the slave side is the ROM.
interface inst_rom_if #(
    parameter int DEPTH_LOG2 = 10,
    parameter int INST_W     = 32,
    parameter int ADDR_W     = 32
) ();

    logic                  ce;
    logic [ADDR_W-1:0]     addr;
    logic [INST_W-1:0]     inst;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [7:0]            ld_byte;
    logic                  ld_last;

    logic                  boot_done;
    logic                  ld_ovf;
    logic [DEPTH_LOG2:0]   ld_count;

    modport master (
        output ce, addr, ld_valid, ld_byte, ld_last,
        input  inst, ld_ready, boot_done, ld_ovf, ld_count
    );

    modport slave (
        input  ce, addr, ld_valid, ld_byte, ld_last,
        output inst, ld_ready, boot_done, ld_ovf, ld_count
    );

endinterface

// File: rtl/inst_rom_loader.sv
// Boot loader: assembles big-endian bytes into words, tracks the stored
// word count and overflow, and produces the memory write strobe.
module inst_rom_loader
    import inst_rom_pkg::*;
#(
    parameter int DEPTH_LOG2 = INST_MEM_NUM_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  boot_done,
    output logic                  ld_ovf,
    output logic [DEPTH_LOG2:0]   ld_count,
    output logic                  wr_en,
    output logic [DEPTH_LOG2-1:0] wr_addr,
    output logic [31:0]           wr_data
);

    localparam logic [DEPTH_LOG2:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};

    ld_state_t           state_reg;
    logic [1:0]          byte_idx_reg;
    logic [31:0]         word_reg;
    logic [DEPTH_LOG2:0] ld_count_reg;
    logic                ld_ovf_reg;
    logic                boot_done_reg;

    logic accept;
    logic word_done;
    logic flush;
    logic wr_req;
    logic has_room;

    assign ld_ready  = (state_reg == LD_LOAD) && (rst != RST_ENABLE_N);
    assign accept    = ld_valid && ld_ready;
    assign word_done = accept && (byte_idx_reg == 2'd3);
    assign flush     = (state_reg == LD_FLUSH) && (rst != RST_ENABLE_N);
    assign wr_req    = word_done || flush;
    assign has_room  = ld_count_reg < CAPACITY;

    // A full word takes the live byte as its last lane; a flush writes the
    // partial word whose unfilled low lanes are still zero.
    assign wr_en   = wr_req && has_room;
    assign wr_addr = ld_count_reg[DEPTH_LOG2-1:0];
    assign wr_data = flush ? word_reg : {word_reg[31:8], ld_byte};

    assign boot_done = boot_done_reg;
    assign ld_ovf    = ld_ovf_reg;
    assign ld_count  = ld_count_reg;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE_N) begin
            state_reg     <= LD_LOAD;
            byte_idx_reg  <= 2'd0;
            word_reg      <= ZERO_WORD;
            ld_count_reg  <= '0;
            ld_ovf_reg    <= 1'b0;
            boot_done_reg <= 1'b0;
        end else begin
            if (wr_req) begin
                if (has_room) begin
                    ld_count_reg <= ld_count_reg + 1'b1;
                end else begin
                    ld_ovf_reg <= 1'b1;
                end
            end

            case (state_reg)
                LD_LOAD: begin
                    if (accept) begin
                        if (byte_idx_reg == 2'd3) begin
                            byte_idx_reg <= 2'd0;
                            word_reg     <= ZERO_WORD;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                            word_reg     <= place_byte(word_reg, byte_idx_reg, ld_byte);
                        end
                        if (ld_last) begin
                            if (byte_idx_reg == 2'd3) begin
                                state_reg     <= LD_DONE;
                                boot_done_reg <= 1'b1;
                            end else begin
                                state_reg <= LD_FLUSH;
                            end
                        end
                    end
                end
                LD_FLUSH: begin
                    state_reg     <= LD_DONE;
                    boot_done_reg <= 1'b1;
                    byte_idx_reg  <= 2'd0;
                    word_reg      <= ZERO_WORD;
                end
                default: begin
                    state_reg <= LD_DONE;
                end
            endcase
        end
    end

endmodule

// File: rtl/inst_rom.sv
// Instruction ROM: storage array filled by the boot loader, with a
// zero-latency fetch read masked until boot completes.
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int DEPTH_LOG2 = INST_MEM_NUM_LOG2,
    parameter int INST_W     = INST_BUS_W,
    parameter int ADDR_W     = INST_ADDR_BUS_W
) (
    input  logic     clk,
    input  logic     rst,
    inst_rom_if.slave bus
);

    logic [INST_W-1:0]     mem [0:(1 << DEPTH_LOG2)-1];

    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [DEPTH_LOG2-1:0] rd_index;
    logic                  rd_hit;
    logic                  unused_addr_bits;

    inst_rom_loader #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_loader (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (bus.ld_valid),
        .ld_byte   (bus.ld_byte),
        .ld_last   (bus.ld_last),
        .ld_ready  (bus.ld_ready),
        .boot_done (bus.boot_done),
        .ld_ovf    (bus.ld_ovf),
        .ld_count  (bus.ld_count),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // No reset on the array: stale words beyond ld_count are masked on read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Byte offset and upper address bits are ignored, so fetches alias
    // modulo the capacity.
    assign rd_index         = bus.addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{bus.addr[ADDR_W-1:DEPTH_LOG2+2], bus.addr[1:0]};

    assign rd_hit = (bus.ce == CHIP_ENABLE) && bus.boot_done &&
                    (rst != RST_ENABLE_N) &&
                    ({1'b0, rd_index} < bus.ld_count);

    always_comb begin
        bus.inst = '0;
        if (rd_hit) begin
            bus.inst = mem[rd_index];
        end
    end

endmodule
